// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised RAM.
// Holds the FSM state enum, default geometry and the RD_LAT legality check.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DEPTH  = 128;
  localparam int DEF_RD_LAT = 1;

  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_rw_param_core.sv
// ram_core: bare storage array, one write port, one registered read port.
// Ports: clk, rd_clr (zero read reg), we/re, rd_zero, addr, wdata -> rdata.
module ram_core #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rd_clr,
  input  logic              we,
  input  logic              re,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] ram_data [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      ram_data[addr] <= wdata;
    end
  end

  // Out-of-range reads return zero without touching the array.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rd_zero ? '0 : ram_data[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_rw_param.sv
// Parametrised single-port RAM with post-reset clear sequencer and rd_valid.
// Ports: clk, rst, read_en, write_en, addr, din -> dout, rd_valid, busy
// (+ parity_err when RAM_PARITY_EN is defined).
module ram_rw_param
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy
`ifdef RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  ram_state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic rd_v1_q, rd_v1_d;

  logic clr_we;
  logic acc;
  logic in_range;
  logic core_we;
  logic core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] core_wdata;
  logic [WORD_W-1:0] rword;
  logic [DATA_W-1:0] rdat;

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
    $error("ram_rw_param: RD_LAT must be 1 or 2");
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = 32'(addr) < DEPTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      rd_v1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_v1_q    <= rd_v1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_addr_q == LAST) begin
          state_d = READY;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Requests arriving in the same cycle as rst are dropped too.
  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    acc    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = !rst;
      end
      READY:   acc  = !rst;
      default: busy = 1'b1;
    endcase
  end

`ifdef RAM_PARITY_EN
  assign word_in = {^din, din};
`else
  assign word_in = din;
`endif

  assign core_we    = clr_we | (acc & write_en & in_range);
  assign core_re    = acc & read_en;
  assign core_addr  = busy ? clr_addr_q : addr;
  assign core_wdata = busy ? '0 : word_in;
  assign rd_v1_d    = core_re;

  ram_core #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rd_clr  (rst),
    .we      (core_we),
    .re      (core_re),
    .rd_zero (!in_range),
    .addr    (core_addr),
    .wdata   (core_wdata),
    .rdata   (rword)
  );

  assign rdat = rword[DATA_W-1:0];

`ifdef RAM_PARITY_EN
  logic mism;
  assign mism = rword[DATA_W] ^ (^rdat);
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] d2_q, d2_d;

    always_comb begin
      v2_d = rd_v1_q;
      d2_d = rd_v1_q ? rdat : d2_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end

    assign rd_valid = v2_q;
    assign dout     = d2_q;

`ifdef RAM_PARITY_EN
    logic p2_q, p2_d;
    assign p2_d = rd_v1_q & mism;
    always_ff @(posedge clk) begin
      if (rst) begin
        p2_q <= 1'b0;
      end else begin
        p2_q <= p2_d;
      end
    end
    assign parity_err = p2_q;
`endif
  end else begin : g_lat1
    assign rd_valid = rd_v1_q;
    assign dout     = rdat;
`ifdef RAM_PARITY_EN
    assign parity_err = rd_v1_q & mism;
`endif
  end

endmodule
